// File: rtl/early_debounce_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : early_debounce_multi                                          |
// | Brief    : N-channel switch debouncer, early or delayed commit, 1-cycle  |
// |            rise/fall ticks and a per-channel lockout busy flag.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module early_debounce_multi #(
    parameter int N_CH        = 4,
    parameter int LOCK_CYCLES = 2000000,
    parameter int EARLY       = 1,
    parameter int CNT_W       = $clog2(LOCK_CYCLES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] rise_tick,
    output logic [N_CH-1:0] fall_tick,
    output logic [N_CH-1:0] busy
);

    localparam logic [1:0]       c_ZERO   = 2'd0;
    localparam logic [1:0]       c_ONE    = 2'd1;
    localparam logic [1:0]       c_WAIT01 = 2'd2;
    localparam logic [1:0]       c_WAIT10 = 2'd3;
    localparam logic [CNT_W-1:0] c_LOAD   = CNT_W'(LOCK_CYCLES - 1);
    localparam logic             c_EARLY  = (EARLY != 0);

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_rise;
        logic             r_fall;
        logic             w_rise_nxt;
        logic             w_fall_nxt;
        logic             w_s;

        assign w_s = r_sync2[g];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= c_ZERO;
                r_cnt   <= '0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_rise  <= w_rise_nxt;
                r_fall  <= w_fall_nxt;
            end
        end

        // Early mode commits on entry to a WAIT state; delayed mode commits on its exit.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_rise_nxt  = 1'b0;
            w_fall_nxt  = 1'b0;
            case (r_state)
                c_ZERO: begin
                    if (w_s) begin
                        w_state_nxt = c_WAIT01;
                        w_cnt_nxt   = c_LOAD;
                        w_rise_nxt  = c_EARLY;
                    end
                end
                c_WAIT01: begin
                    if (!c_EARLY && !w_s) begin
                        w_state_nxt = c_ZERO;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = c_ONE;
                        w_rise_nxt  = !c_EARLY;
                    end else begin
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end
                end
                c_ONE: begin
                    if (!w_s) begin
                        w_state_nxt = c_WAIT10;
                        w_cnt_nxt   = c_LOAD;
                        w_fall_nxt  = c_EARLY;
                    end
                end
                c_WAIT10: begin
                    if (!c_EARLY && w_s) begin
                        w_state_nxt = c_ONE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = c_ZERO;
                        w_fall_nxt  = !c_EARLY;
                    end else begin
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ZERO;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign db_out[g]    = c_EARLY ? (r_state == c_ONE || r_state == c_WAIT01)
                                      : (r_state == c_ONE || r_state == c_WAIT10);
        assign busy[g]      = (r_state == c_WAIT01) || (r_state == c_WAIT10);
        assign rise_tick[g] = r_rise;
        assign fall_tick[g] = r_fall;
    end

endmodule
`default_nettype wire

// File: tb/tb_early_debounce_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_early_debounce_multi                                       |
// | Brief    : Bench for early_debounce_multi, early and delayed instances.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_early_debounce_multi;

    localparam int N    = 4;
    localparam int LOCK = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] in_v = '0;
    logic [N-1:0] db_e, rise_e, fall_e, busy_e;
    logic [N-1:0] db_d, rise_d, fall_d, busy_d;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    early_debounce_multi #(.N_CH(N), .LOCK_CYCLES(LOCK), .EARLY(1)) u_early (
        .clk(clk), .reset(reset), .in(in_v),
        .db_out(db_e), .rise_tick(rise_e), .fall_tick(fall_e), .busy(busy_e)
    );

    early_debounce_multi #(.N_CH(N), .LOCK_CYCLES(LOCK), .EARLY(0)) u_delay (
        .clk(clk), .reset(reset), .in(in_v),
        .db_out(db_d), .rise_tick(rise_d), .fall_tick(fall_d), .busy(busy_d)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Reference: input seen by the debouncer is in[] two edges late. Early mode
    // flips on a mismatch once LOCK+1 edges have passed since the last flip;
    // delayed mode flips after LOCK+1 consecutive mismatching samples.
    logic [N-1:0] p1 = '0, p2 = '0;
    logic [N-1:0] m_db_e = '0, m_rise_e = '0, m_fall_e = '0, m_busy_e = '0;
    logic [N-1:0] m_db_d = '0, m_rise_d = '0, m_fall_d = '0, m_busy_d = '0;
    int last_flip [N] = '{default: -100};
    int run_len   [N] = '{default: 0};

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int c = 0; c < N; c++) begin
            m_rise_e[c] = 1'b0; m_fall_e[c] = 1'b0;
            m_rise_d[c] = 1'b0; m_fall_d[c] = 1'b0;
            if (reset) begin
                p1[c] = 1'b0; p2[c] = 1'b0;
                m_db_e[c] = 1'b0; m_busy_e[c] = 1'b0; last_flip[c] = -100;
                m_db_d[c] = 1'b0; m_busy_d[c] = 1'b0; run_len[c] = 0;
            end else begin
                logic s;
                s = p2[c];
                p2[c] = p1[c];
                p1[c] = in_v[c];
                if (cyc >= last_flip[c] + LOCK + 1 && s != m_db_e[c]) begin
                    m_db_e[c] = s;
                    m_rise_e[c] = s;
                    m_fall_e[c] = !s;
                    last_flip[c] = cyc;
                end
                m_busy_e[c] = (cyc - last_flip[c]) < LOCK;
                run_len[c] = (s != m_db_d[c]) ? run_len[c] + 1 : 0;
                if (run_len[c] == LOCK + 1) begin
                    m_db_d[c] = s;
                    m_rise_d[c] = s;
                    m_fall_d[c] = !s;
                    run_len[c] = 0;
                end
                m_busy_d[c] = (run_len[c] != 0);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_db_early",   db_e,   m_db_e);
            chk("model_rise_early", rise_e, m_rise_e);
            chk("model_fall_early", fall_e, m_fall_e);
            chk("model_busy_early", busy_e, m_busy_e);
            chk("model_db_delay",   db_d,   m_db_d);
            chk("model_rise_delay", rise_d, m_rise_d);
            chk("model_fall_delay", fall_d, m_fall_d);
            chk("model_busy_delay", busy_d, m_busy_d);
        end
    end

    task automatic at(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_v  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k;
        int nr, nf;
        int mode [N];
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;
        chk("reset_db_early",   db_e,   0);
        chk("reset_busy_early", busy_e, 0);
        chk("reset_db_delay",   db_d,   0);
        chk("reset_ticks",      {rise_e, fall_e, rise_d, fall_d}, 0);
        repeat (2) @(negedge clk);

        // Clean rise on channel 0
        k = cyc + 1; in_v[0] = 1'b1;
        at(k + 1);  chk("c1_db_before",   db_e[0], 0);
        at(k + 2);  chk("c1_db_rise",     {db_e[0], rise_e[0], busy_e[0]}, 3'b111);
        at(k + 3);  chk("c1_tick_once",   {rise_e[0], busy_e[0]}, 2'b01);
        at(k + 9);  chk("c1_busy_last",   {busy_e[0], busy_d[0], db_d[0]}, 3'b110);
        at(k + 10); chk("c1_one",         {db_e[0], busy_e[0]}, 2'b10);
                    chk("c1_delay_rise",  {db_d[0], rise_d[0], busy_d[0]}, 3'b110);
        do_reset();

        // Bouncing rise on channel 1
        k = cyc + 1; nr = 0; nf = 0;
        for (int i = 0; i < 31; i++) begin
            if (i <= 6) in_v[1] = (i % 2 == 0);
            @(negedge clk);
            nr += rise_e[1]; nf += fall_e[1];
        end
        chk("c2_rise_count", nr, 1);
        chk("c2_fall_count", nf, 0);
        chk("c2_levels",     {db_e[1], db_d[1]}, 2'b11);
        do_reset();

        // Short pulse then long hold on channel 2 (delayed mode)
        k = cyc + 1; in_v[2] = 1'b1;
        at(k + 2);  in_v[2] = 1'b0;
        at(k + 4);  chk("c3_busy_pulse",  busy_d[2], 1);
        at(k + 5);  chk("c3_abort",       {busy_d[2], db_d[2]}, 2'b00);
        at(k + 13); chk("c3_no_commit",   db_d[2], 0);
        k = cyc + 1; in_v[2] = 1'b1;
        at(k + 9);  chk("c3_hold_wait",   db_d[2], 0);
        at(k + 10); chk("c3_hold_rise",   {db_d[2], rise_d[2]}, 2'b11);
        do_reset();

        // Return-to-low during WAIT01 on channel 3
        k = cyc + 1; in_v[3] = 1'b1;
        at(k + 2);  in_v[3] = 1'b0;
        at(k + 10); chk("c4_one_cycle",   {db_e[3], busy_e[3], fall_e[3]}, 3'b100);
        at(k + 11); chk("c4_fall",        {db_e[3], busy_e[3], fall_e[3]}, 3'b011);
        at(k + 18); chk("c4_busy_end",    busy_e[3], 1);
        at(k + 19); chk("c4_zero",        {db_e[3], busy_e[3]}, 2'b00);
        do_reset();

        // Reset in the middle of WAIT01 on channel 1
        k = cyc + 1; in_v[1] = 1'b1;
        at(k + 4);  reset = 1'b1;
        at(k + 5);  reset = 1'b0;
                    chk("c5_reset_abort", {db_e[1], busy_e[1], rise_e[1], fall_e[1]}, 4'b0000);
        at(k + 7);  chk("c5_resync",      db_e[1], 0);
        at(k + 8);  chk("c5_redetect",    {db_e[1], rise_e[1]}, 2'b11);
        do_reset();

        // All channels together
        k = cyc + 1; in_v = '1;
        at(k + 2);  chk("c6_all_early",   {db_e, rise_e, busy_e}, 12'hFFF);
        at(k + 3);  chk("c6_all_after",   {rise_e, busy_e}, 8'h0F);
        at(k + 10); chk("c6_all_delay",   {db_d, rise_d}, 8'hFF);
        do_reset();

        // Randomised mix of quiet, bouncing and slowly toggling channels
        for (int c = 0; c < N; c++) mode[c] = 0;
        for (int t = 0; t < 4000; t++) begin
            if (t % 40 == 0)
                for (int c = 0; c < N; c++) mode[c] = $urandom_range(0, 2);
            for (int c = 0; c < N; c++) begin
                if (mode[c] == 1 && $urandom_range(0, 1) == 1)  in_v[c] = !in_v[c];
                if (mode[c] == 2 && $urandom_range(0, 11) == 0) in_v[c] = !in_v[c];
            end
            reset = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        repeat (30) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
